// File: rtl/vcache_stat_sampler_if.sv
// Record stream from the stat sampler to the host-side collector, plus FSM debug taps.
// Handshake: a word transfers on every cycle where v_o & ready_i; while v_o=1 and
// ready_i=0 the word is held unchanged, and v_o never depends on ready_i.
`timescale 1ns/1ps
interface vcache_stat_sampler_if #(
    parameter int data_width_p = 32
);
    logic [data_width_p-1:0] data_o;
    logic                    v_o;
    logic                    ready_i;
    logic                    dbg_send;
    logic [2:0]              dbg_widx;

    modport master (
        output data_o,
        output v_o,
        output dbg_send,
        output dbg_widx,
        input  ready_i
    );

    modport slave (
        input  data_o,
        input  v_o,
        input  dbg_send,
        input  dbg_widx,
        output ready_i
    );
endinterface

// File: rtl/vcache_stat_sampler.sv
// Counts accepted vcache loads/stores/misses, snapshots them on request into a
// record FIFO, and serializes each record as six words over a valid/ready port.
`timescale 1ns/1ps
module vcache_stat_sampler #(
    parameter int data_width_p = 32,
    parameter int fifo_els_p   = 4
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    input  logic                    v_i,
    input  logic                    yumi_i,
    input  logic                    ld_op_i,
    input  logic                    st_op_i,
    input  logic                    miss_i,
    input  logic [31:0]             global_ctr_i,
    input  logic                    print_stat_v_i,
    input  logic [data_width_p-1:0] print_stat_tag_i,
    input  logic                    clear_i,
    vcache_stat_sampler_if.master   stat_out,
    output logic                    drop_o,
    output logic [7:0]              drop_count_o
);
    localparam int addr_w_lp = $clog2(fifo_els_p);
    localparam logic [addr_w_lp:0] depth_lp = (addr_w_lp+1)'(fifo_els_p);
    localparam logic [addr_w_lp:0] one_lp   = (addr_w_lp+1)'(1);

    typedef logic [data_width_p-1:0] word_t;
    typedef logic [5:0][data_width_p-1:0] rec_t;
    typedef enum logic {IDLE, SEND} state_e;

    function automatic word_t sat_inc(input word_t val, input logic en);
        if (en && (val != '1)) return val + word_t'(1);
        return val;
    endfunction

    word_t ld_r, st_r, ld_miss_r, st_miss_r;
    word_t ld_post, st_post, ld_miss_post, st_miss_post;
    word_t gctr_ext;
    logic  acc;

    // Post-increment values feed both the snapshot and the counter update.
    always_comb begin
        acc          = v_i & yumi_i;
        ld_post      = sat_inc(ld_r,      acc & ld_op_i);
        st_post      = sat_inc(st_r,      acc & st_op_i);
        ld_miss_post = sat_inc(ld_miss_r, acc & ld_op_i & miss_i);
        st_miss_post = sat_inc(st_miss_r, acc & st_op_i & miss_i);
        gctr_ext       = '0;
        gctr_ext[31:0] = global_ctr_i;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            ld_r      <= '0;
            st_r      <= '0;
            ld_miss_r <= '0;
            st_miss_r <= '0;
        end else if (clear_i) begin
            ld_r      <= '0;
            st_r      <= '0;
            ld_miss_r <= '0;
            st_miss_r <= '0;
        end else begin
            ld_r      <= ld_post;
            st_r      <= st_post;
            ld_miss_r <= ld_miss_post;
            st_miss_r <= st_miss_post;
        end
    end

    rec_t               mem_r [fifo_els_p];
    rec_t               rec_in, head;
    logic [addr_w_lp:0] wptr_r, rptr_r, count;
    logic               full, empty, push, pop, drop_evt;
    state_e             state_r, state_n;
    logic [2:0]         widx_r, widx_n;
    word_t              data_word;

    always_comb begin
        count    = wptr_r - rptr_r;
        full     = (count == depth_lp);
        empty    = (count == '0);
        pop      = (state_r == SEND) & stat_out.ready_i & (widx_r == 3'd5);
        // The slot freed by a final-word pop is reusable in the same cycle.
        push     = print_stat_v_i & (~full | pop);
        drop_evt = print_stat_v_i & full & ~pop;
        rec_in[0] = gctr_ext;
        rec_in[1] = print_stat_tag_i;
        rec_in[2] = ld_post;
        rec_in[3] = st_post;
        rec_in[4] = ld_miss_post;
        rec_in[5] = st_miss_post;
        head      = mem_r[rptr_r[addr_w_lp-1:0]];
    end

    always_ff @(posedge clk_i) begin
        if (push) mem_r[wptr_r[addr_w_lp-1:0]] <= rec_in;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wptr_r       <= '0;
            rptr_r       <= '0;
            drop_o       <= 1'b0;
            drop_count_o <= 8'd0;
        end else begin
            if (push) wptr_r <= wptr_r + one_lp;
            if (pop)  rptr_r <= rptr_r + one_lp;
            if (drop_evt) begin
                drop_o <= 1'b1;
                if (drop_count_o != 8'hFF) drop_count_o <= drop_count_o + 8'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r <= IDLE;
            widx_r  <= 3'd0;
        end else begin
            state_r <= state_n;
            widx_r  <= widx_n;
        end
    end

    // A same-cycle push counts as occupancy so word 0 appears one cycle after the request.
    always_comb begin
        state_n = state_r;
        widx_n  = widx_r;
        case (state_r)
            IDLE: begin
                if (!empty || push) begin
                    state_n = SEND;
                    widx_n  = 3'd0;
                end
            end
            SEND: begin
                if (stat_out.ready_i) begin
                    if (widx_r == 3'd5) begin
                        widx_n  = 3'd0;
                        state_n = ((count > one_lp) || push) ? SEND : IDLE;
                    end else begin
                        widx_n = widx_r + 3'd1;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                widx_n  = 3'd0;
            end
        endcase
    end

    always_comb begin
        data_word = '0;
        if (state_r == SEND) begin
            case (widx_r)
                3'd0:    data_word = head[0];
                3'd1:    data_word = head[1];
                3'd2:    data_word = head[2];
                3'd3:    data_word = head[3];
                3'd4:    data_word = head[4];
                3'd5:    data_word = head[5];
                default: data_word = '0;
            endcase
        end
    end

    assign stat_out.v_o      = (state_r == SEND);
    assign stat_out.data_o   = data_word;
    assign stat_out.dbg_send = (state_r == SEND);
    assign stat_out.dbg_widx = widx_r;
endmodule

// File: tb/tb_vcache_stat_sampler.sv
// Directed bench for vcache_stat_sampler: a word-queue model of the record stream
// checked every cycle, plus literal expectations for each scenario.
`timescale 1ns/1ps
module tb_vcache_stat_sampler;
    localparam int dw = 32;

    // clock / reset
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          v = 0, yumi = 0, ld_op = 0, st_op = 0, miss = 0, prt = 0, clr = 0;
    logic [31:0]   gctr = 0;
    logic [dw-1:0] tag = 0;
    logic          drop;
    logic [7:0]    dcnt;

    vcache_stat_sampler_if #(.data_width_p(dw)) stat_if();

    vcache_stat_sampler #(.data_width_p(dw), .fifo_els_p(4)) dut (
        .clk_i            (clk),
        .reset_n_i        (rst_n),
        .v_i              (v),
        .yumi_i           (yumi),
        .ld_op_i          (ld_op),
        .st_op_i          (st_op),
        .miss_i           (miss),
        .global_ctr_i     (gctr),
        .print_stat_v_i   (prt),
        .print_stat_tag_i (tag),
        .clear_i          (clr),
        .stat_out         (stat_if.master),
        .drop_o           (drop),
        .drop_count_o     (dcnt)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // model: counters plus the queue of words the port still owes
    logic [31:0] exp_q[$];
    logic [31:0] got_q[$];
    logic [31:0] m_ld = 0, m_st = 0, m_ldm = 0, m_stm = 0;
    logic [31:0] n_ld, n_st, n_ldm, n_stm;
    logic        m_drop = 0;
    logic [7:0]  m_dcnt = 0;
    logic        acc_m;

    function automatic logic [31:0] sat(input logic [31:0] c, input bit en);
        longint s;
        s = longint'(c) + (en ? 1 : 0);
        if (s > longint'(32'hFFFF_FFFF)) return 32'hFFFF_FFFF;
        return s[31:0];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ld = 0; m_st = 0; m_ldm = 0; m_stm = 0;
            m_drop = 0; m_dcnt = 0;
            exp_q.delete();
        end else begin
            if (exp_q.size() > 0 && stat_if.ready_i) void'(exp_q.pop_front());
            acc_m = v && yumi;
            n_ld  = sat(m_ld,  acc_m && ld_op);
            n_st  = sat(m_st,  acc_m && st_op);
            n_ldm = sat(m_ldm, acc_m && ld_op && miss);
            n_stm = sat(m_stm, acc_m && st_op && miss);
            if (prt) begin
                if ((exp_q.size() + 5) / 6 < 4) begin
                    exp_q.push_back(gctr);
                    exp_q.push_back(tag);
                    exp_q.push_back(n_ld);
                    exp_q.push_back(n_st);
                    exp_q.push_back(n_ldm);
                    exp_q.push_back(n_stm);
                end else begin
                    m_drop = 1;
                    if (m_dcnt != 8'hFF) m_dcnt = m_dcnt + 8'd1;
                end
            end
            if (clr) begin
                m_ld = 0; m_st = 0; m_ldm = 0; m_stm = 0;
            end else begin
                m_ld = n_ld; m_st = n_st; m_ldm = n_ldm; m_stm = n_stm;
            end
        end
    end

    // per-cycle compare, mid-cycle
    always @(negedge clk) begin
        if (rst_n) begin
            chk("v_o", {31'd0, stat_if.v_o}, {31'd0, exp_q.size() > 0});
            if (exp_q.size() > 0) chk("data_o", stat_if.data_o, exp_q[0]);
            else                  chk("data_idle", stat_if.data_o, 32'd0);
            chk("drop_o", {31'd0, drop}, {31'd0, m_drop});
            chk("drop_count", {24'd0, dcnt}, {24'd0, m_dcnt});
            if (stat_if.v_o && stat_if.ready_i) got_q.push_back(stat_if.data_o);
        end
    end

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input logic a, input logic y, input logic l, input logic s, input logic m,
                       input logic p, input logic c, input logic [31:0] t, input logic [31:0] g);
        v = a; yumi = y; ld_op = l; st_op = s; miss = m; prt = p; clr = c; tag = t; gctr = g;
        step();
        v = 0; yumi = 0; ld_op = 0; st_op = 0; miss = 0; prt = 0; clr = 0;
    endtask

    task automatic drain();
        stat_if.ready_i = 1'b1;
        for (int i = 0; i < 200 && exp_q.size() > 0; i++) step();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: words_left=%0d expected=0", exp_q.size());
        end
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [31:0] e1 [6];

    initial begin
        stat_if.ready_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_v_o", {31'd0, stat_if.v_o}, 32'd0);
        chk("rst_data_o", stat_if.data_o, 32'd0);
        chk("rst_drop_o", {31'd0, drop}, 32'd0);
        chk("rst_drop_count", {24'd0, dcnt}, 32'd0);
        rst_n = 1'b1;
        step();

        // 3 loads (1 miss), 2 stores (2 misses), one unaccepted load
        got_q.delete();
        cyc(1, 1, 1, 0, 1, 0, 0, 0, 0);
        cyc(1, 1, 1, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 1, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 0, 1, 1, 0, 0, 0, 0);
        cyc(1, 1, 0, 1, 1, 0, 0, 0, 0);
        cyc(1, 0, 1, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 1, 0, 32'hA5, 32'd100);
        chk("lat_v_o", {31'd0, stat_if.v_o}, 32'd1);
        chk("lat_word0", stat_if.data_o, 32'd100);
        drain();
        e1 = '{32'd100, 32'hA5, 32'd3, 32'd2, 32'd1, 32'd2};
        chk("rec1_len", got_q.size(), 32'd6);
        for (int i = 0; i < 6 && i < got_q.size(); i++) chk("rec1_word", got_q[i], e1[i]);

        // same-cycle load with print, then with print+clear, then a post-clear print
        got_q.delete();
        cyc(1, 1, 1, 0, 0, 1, 0, 32'd1, 32'd200);
        cyc(1, 1, 1, 0, 0, 1, 1, 32'd2, 32'd201);
        cyc(0, 0, 0, 0, 0, 1, 0, 32'd3, 32'd202);
        drain();
        chk("rec2_len", got_q.size(), 32'd18);
        if (got_q.size() == 18) begin
            chk("same_cycle_ld", got_q[2], 32'd4);
            chk("clear_snap_ld", got_q[8], 32'd5);
            chk("clear_snap_st", got_q[9], 32'd2);
            chk("clear_snap_ldm", got_q[10], 32'd1);
            chk("after_clear_ld", got_q[14], 32'd0);
            chk("after_clear_st", got_q[15], 32'd0);
            chk("after_clear_stm", got_q[17], 32'd0);
        end

        // stall at widx=3
        got_q.delete();
        cyc(1, 1, 0, 1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 1, 0, 32'h33, 32'd300);
        step(); step(); step();
        stat_if.ready_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk("stall_v_o", {31'd0, stat_if.v_o}, 32'd1);
            chk("stall_data", stat_if.data_o, 32'd1);
            step();
        end
        drain();
        chk("stall_len", got_q.size(), 32'd6);
        if (got_q.size() == 6) begin
            chk("stall_w0", got_q[0], 32'd300);
            chk("stall_w3", got_q[3], 32'd1);
            chk("stall_w4", got_q[4], 32'd0);
            chk("stall_w5", got_q[5], 32'd0);
        end

        // overflow: 6 prints into a 4-deep FIFO, then a push on the final-word pop
        got_q.delete();
        stat_if.ready_i = 1'b0;
        for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0, 0, 1, 0, 32'd10 + i, 32'd400 + i);
        chk("ovf_drop_o", {31'd0, drop}, 32'd1);
        chk("ovf_drop_count", {24'd0, dcnt}, 32'd2);
        stat_if.ready_i = 1'b1;
        repeat (5) step();
        cyc(0, 0, 0, 0, 0, 1, 0, 32'd99, 32'd999);
        chk("full_pop_push_dcnt", {24'd0, dcnt}, 32'd2);
        drain();
        chk("ovf_len", got_q.size(), 32'd30);
        if (got_q.size() == 30) begin
            for (int r = 0; r < 4; r++) begin
                chk("ovf_gctr", got_q[r*6], 32'd400 + r);
                chk("ovf_tag", got_q[r*6+1], 32'd10 + r);
            end
            chk("ovf_tag_last", got_q[25], 32'd99);
        end

        // saturation of ld
        got_q.delete();
        force dut.ld_r = 32'hFFFF_FFFE;
        m_ld = 32'hFFFF_FFFE;
        cyc(1, 1, 1, 0, 0, 0, 0, 0, 0);
        release dut.ld_r;
        cyc(1, 1, 1, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 1, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 1, 0, 32'd5, 32'd500);
        drain();
        chk("sat_len", got_q.size(), 32'd6);
        if (got_q.size() == 6) chk("sat_ld", got_q[2], 32'hFFFF_FFFF);

        // reset mid-record at widx=2
        cyc(0, 0, 0, 0, 0, 1, 0, 32'h77, 32'd600);
        step(); step();
        rst_n = 1'b0;
        #1;
        chk("midrst_v_o", {31'd0, stat_if.v_o}, 32'd0);
        chk("midrst_data", stat_if.data_o, 32'd0);
        chk("midrst_drop", {31'd0, drop}, 32'd0);
        step(); step();
        rst_n = 1'b1;
        got_q.delete();
        repeat (3) step();
        chk("postrst_v_o", {31'd0, stat_if.v_o}, 32'd0);
        cyc(0, 0, 0, 0, 0, 1, 0, 32'h88, 32'd700);
        drain();
        chk("postrst_len", got_q.size(), 32'd6);
        if (got_q.size() == 6) begin
            chk("postrst_tag", got_q[1], 32'h88);
            chk("postrst_ld", got_q[2], 32'd0);
            chk("postrst_st", got_q[3], 32'd0);
            chk("postrst_ldm", got_q[4], 32'd0);
            chk("postrst_stm", got_q[5], 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
